// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the elastic pipeline-register chain: default sizes and a popcount helper.
package pipe_reg_chain_pkg;

  localparam int PIPE_DEFAULT_WIDTH = 64;
  localparam int PIPE_DEFAULT_DEPTH = 4;

  // Widest vector popcount() accepts; callers zero-extend their vector to this width.
  localparam int POPCNT_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      n += 32'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register stage of the chain: payload register plus valid bit.
// Load wins over clear so a stage that hands off and receives in the same cycle keeps the new item.
module pipe_slot
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = PIPE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  logic             v_d, v_q;
  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (load) begin
      v_d = 1'b1;
      q_d = d;
    end else if (clear) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      q_q <= '0;
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

  assign q = q_q;
  assign v = v_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with valid/ready backpressure, bubble collapse and per-stage kill.
// Optional live-item counter on occ is built only when PIPE_CHAIN_OCC_EN is defined.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = PIPE_DEFAULT_WIDTH,
  parameter int DEPTH = PIPE_DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic [DEPTH-1:0]           flush_mask,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] data   [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];

  // Ready ripples from the output toward the input; an empty or killed slot always accepts.
  always_comb begin
    ev         = v & ~flush_mask;
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ~ev[i] | rdy[i+1];
    end
    load      = '0;
    clear     = '0;
    slot_d[0] = in_data;
    load[0]   = in_valid & rdy[0];
    for (int i = 1; i < DEPTH; i++) begin
      load[i]   = ev[i-1] & rdy[i];
      slot_d[i] = data[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      clear[i] = (ev[i] & rdy[i+1]) | (v[i] & flush_mask[i]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pipe_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .clear (clear[g]),
      .d     (slot_d[g]),
      .q     (data[g]),
      .v     (v[g])
    );
  end

  assign in_ready    = rdy[0];
  assign out_valid   = ev[DEPTH-1];
  assign out_data    = data[DEPTH-1];
  assign stage_valid = v;

`ifdef PIPE_CHAIN_OCC_EN
  logic             push, pop;
  int               occ_next;
  logic [OCC_W-1:0] occ_d, occ_q;

  // Killed items leave the count the same cycle they are squashed, whether or not a push lands on them.
  always_comb begin
    push     = in_valid & rdy[0];
    pop      = ev[DEPTH-1] & out_ready;
    occ_next = int'(occ_q) + int'(push) - int'(pop)
             - int'(popcount(POPCNT_MAX_W'(v & flush_mask)));
    occ_d    = OCC_W'(occ_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  a_occ_range: assert property (@(posedge clk) disable iff (rst)
    (occ_next >= 0) && (occ_next <= DEPTH));

  assign occ = occ_q;
`else
  assign occ = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed bench for pipe_reg_chain (WIDTH=8, DEPTH=4) against an item-level slot model.
module tb_pipe_reg_chain;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int OW = $clog2(D+1);
`ifdef PIPE_CHAIN_OCC_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [D-1:0]  flush_mask, stage_valid;
  logic [OW-1:0] occ;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush_mask  (flush_mask),
    .stage_valid (stage_valid),
    .occ         (occ)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: one entry per stage; data persists in a vacated slot, like a real register.
  logic         m_v  [D];
  logic [W-1:0] m_d  [D];
  logic         nx_v [D];
  logic [W-1:0] nx_d [D];
  logic         exp_in_ready, pushed, popped;
  logic [W-1:0] popped_data;
  int           cyc = 0;
  int           dut_acc = 0;
  logic [W-1:0] out_log [$];
  int           acc_q [$];
  int           pop_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Items move as far forward as the space ahead of them frees up, walking from the output side.
  task automatic model_eval();
    logic free_above;
    for (int i = 0; i < D; i++) begin
      nx_v[i] = m_v[i] & ~flush_mask[i];
      nx_d[i] = m_d[i];
    end
    popped      = nx_v[D-1] & out_ready;
    popped_data = m_d[D-1];
    free_above  = out_ready;
    for (int i = D - 1; i >= 0; i--) begin
      if (nx_v[i] && free_above) begin
        if (i < D - 1) begin
          nx_v[i+1] = 1'b1;
          nx_d[i+1] = nx_d[i];
        end
        nx_v[i] = 1'b0;
      end
      free_above = !nx_v[i];
    end
    exp_in_ready = free_above;
    pushed       = in_valid & exp_in_ready;
    if (pushed) begin
      nx_v[0] = 1'b1;
      nx_d[0] = in_data;
    end
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        nx_v[i] = 1'b0;
        nx_d[i] = '0;
      end
      pushed = 1'b0;
      popped = 1'b0;
    end
  endtask

  function automatic logic [D-1:0] model_sv();
    logic [D-1:0] s;
    for (int i = 0; i < D; i++) s[i] = m_v[i];
    return s;
  endfunction

  function automatic int model_occ();
    int n;
    n = 0;
    for (int i = 0; i < D; i++) n += int'(m_v[i]);
    return OCC_EN ? n : 0;
  endfunction

  task automatic cycle(input bit chk);
    @(negedge clk);
    model_eval();
    if (chk) begin
      check("in_ready",    64'(in_ready),    64'(exp_in_ready));
      check("out_valid",   64'(out_valid),   64'(m_v[D-1] & ~flush_mask[D-1]));
      check("out_data",    64'(out_data),    64'(m_d[D-1]));
      check("stage_valid", 64'(stage_valid), 64'(model_sv()));
      check("occ",         64'(occ),         64'(model_occ()));
    end
    if (!rst && in_valid && in_ready) dut_acc++;
    @(posedge clk);
    if (pushed) acc_q.push_back(cyc);
    if (popped) begin
      pop_q.push_back(cyc);
      out_log.push_back(popped_data);
    end
    for (int i = 0; i < D; i++) begin
      m_v[i] = nx_v[i];
      m_d[i] = nx_d[i];
    end
    cyc++;
    #1;
  endtask

  task automatic check_log(input string tag, input logic [W-1:0] exp [$]);
    check({tag, "_count"}, 64'(out_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_log.size(); i++) begin
      check(tag, 64'(out_log[i]), 64'(exp[i]));
    end
  endtask

  logic [W-1:0] s2 [3] = '{8'h11, 8'h22, 8'h33};
  logic [W-1:0] s5 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [W-1:0] exp_q [$];
  int           nxt;

  initial begin
    for (int i = 0; i < D; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0; flush_mask = '0;

    // Reset held for two cycles with an item offered.
    cycle(1'b0);
    cycle(1'b1);
    check("rst_stage_valid", 64'(stage_valid), 64'(0));
    check("rst_out_valid",   64'(out_valid),   64'(0));
    check("rst_out_data",    64'(out_data),    64'(0));
    check("rst_in_ready",    64'(in_ready),    64'(1));
    check("rst_occ",         64'(occ),         64'(0));
    rst = 1'b0; in_valid = 1'b0;

    // Streaming: latency DEPTH, one item per cycle.
    out_log.delete(); acc_q.delete(); pop_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = s2[k];
      cycle(1'b1);
    end
    in_valid = 1'b0;
    repeat (6) cycle(1'b1);
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_log("stream", exp_q);
    if (acc_q.size() == 3 && pop_q.size() == 3) begin
      check("stream_latency", 64'(pop_q[0] - acc_q[0]), 64'(4));
      check("stream_rate",    64'(pop_q[2] - pop_q[0]), 64'(2));
    end else begin
      check("stream_handshakes", 64'(acc_q.size() * 10 + pop_q.size()), 64'(33));
    end

    // Backpressure: only DEPTH items fit, then drain in order.
    out_log.delete(); dut_acc = 0;
    out_ready = 1'b0; in_valid = 1'b1; nxt = 1;
    repeat (8) begin
      in_data = 8'(nxt);
      cycle(1'b1);
      if (pushed) nxt++;
    end
    check("bp_accepted",    64'(dut_acc),     64'(4));
    check("bp_in_ready",    64'(in_ready),    64'(0));
    check("bp_stage_valid", 64'(stage_valid), 64'(4'b1111));
    check("bp_occ",         64'(occ),         64'(OCC_EN ? 4 : 0));
    out_ready = 1'b1;
    repeat (14) begin
      in_data  = 8'(nxt);
      in_valid = (nxt <= 6);
      cycle(1'b1);
      if (pushed) nxt++;
    end
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    check_log("bp_drain", exp_q);

    // Bubble collapse into a stalled, empty chain.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    cycle(1'b1);
    in_valid = 1'b0;
    repeat (3) cycle(1'b1);
    check("bubble_out_valid",   64'(out_valid),   64'(1));
    check("bubble_out_data",    64'(out_data),    64'(8'h5A));
    check("bubble_stage_valid", 64'(stage_valid), 64'(4'b1000));
    check("bubble_in_ready",    64'(in_ready),    64'(1));
    out_ready = 1'b1;
    repeat (2) cycle(1'b1);

    // Partial flush of the two input-side stages.
    out_log.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = s5[k];
      cycle(1'b1);
    end
    in_valid = 1'b0; out_ready = 1'b1; flush_mask = 4'b0011;
    cycle(1'b1);
    check("flush_occ",         64'(occ),         64'(OCC_EN ? 1 : 0));
    check("flush_stage_valid", 64'(stage_valid), 64'(4'b1000));
    flush_mask = '0;
    repeat (4) cycle(1'b1);
    exp_q = '{8'hA1, 8'hB2};
    check_log("flush", exp_q);

    // Output kill plus stage-0 kill while a new item is pushed.
    out_log.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h66;
    cycle(1'b1);
    in_valid = 1'b0;
    repeat (2) cycle(1'b1);
    in_valid = 1'b1; in_data = 8'h67;
    cycle(1'b1);
    out_ready = 1'b1; flush_mask = 4'b1001; in_valid = 1'b1; in_data = 8'h77;
    #1;
    check("kill_out_valid", 64'(out_valid), 64'(0));
    check("kill_in_ready",  64'(in_ready),  64'(1));
    check("kill_occ_pre",   64'(occ),       64'(OCC_EN ? 2 : 0));
    cycle(1'b1);
    check("kill_occ_post",     64'(occ),         64'(OCC_EN ? 1 : 0));
    check("kill_stage_valid",  64'(stage_valid), 64'(4'b0001));
    flush_mask = '0; in_valid = 1'b0;
    repeat (6) cycle(1'b1);
    exp_q = '{8'h77};
    check_log("kill", exp_q);

    // Random traffic with occasional flushes and resets.
    repeat (400) begin
      rst        = ($urandom_range(0, 99) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      cycle(1'b1);
    end
    rst = 1'b0; in_valid = 1'b0; flush_mask = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
